// File: rtl/prio_grant_sched_pkg.sv
// Shared definitions for the four-requester priority grant scheduler:
// state encoding, requester count and the fixed-priority pick function.
package prio_grant_sched_pkg;

    localparam int NREQ = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } pick_t;

    // Lowest-index starved candidate wins; with none starved, lowest-index
    // candidate wins. The caller passes only eligible requesters in req.
    function automatic pick_t pick4(input logic [NREQ-1:0] req,
                                    input logic [NREQ-1:0] starved);
        pick_t           r;
        logic [NREQ-1:0] cand;
        r    = '0;
        cand = ((req & starved) != '0) ? (req & starved) : req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                r.vld = 1'b1;
                r.idx = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_sched_wait_cnt.sv
// Per-requester saturating wait counter. Counts cycles a requester spends
// asking without holding the grant; flags it starved at the limit.
module prio_sched_wait_cnt
    import prio_grant_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int WCW          = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic gnt_i,
    output logic starved
);

    logic [WCW-1:0] wait_cnt_q;
    logic [WCW-1:0] wait_cnt_d;

    // Clear while granted or idle, otherwise count up and stick at the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_i || gnt_i) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WCW'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign starved = (wait_cnt_q == WCW'(STARVE_LIMIT));

endmodule

// File: rtl/prio_grant_sched.sv
// Four-requester fixed-priority scheduler with a per-ownership hold limit,
// a one-cycle dead turn between owners, and starvation aging.
// All outputs are registered and decoded from the next state / next owner.
module prio_grant_sched
    import prio_grant_sched_pkg::*;
#(
    parameter int MAX_HOLD     = 8,
    parameter int STARVE_LIMIT = 16,
    parameter int HCW          = 4,
    parameter int WCW          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       expire
);

    logic [1:0]     state_q, state_d;
    logic [1:0]     owner_q, owner_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           expire_q, expire_d;

    logic [3:0]     starved;
    logic [3:0]     others;
    logic [3:0]     elig;
    pick_t          win;

    for (genvar i = 0; i < NREQ; i++) begin : g_wait
        prio_sched_wait_cnt #(
            .STARVE_LIMIT (STARVE_LIMIT),
            .WCW          (WCW)
        ) u_wait (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_i   (req[i]),
            .gnt_i   (gnt_q[i]),
            .starved (starved[i])
        );
    end

    // Next-state, next-owner and hold logic; outputs decoded from the next values.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        expire_d = 1'b0;
        // In TURN the outgoing owner only gets back in if nobody else asks.
        others   = req & ~(4'b0001 << owner_q);
        elig     = req;
        win      = '0;
        case (state_q)
            IDLE: begin
                win = pick4(elig, starved);
                if (win.vld) begin
                    state_d = GRANT;
                    owner_d = win.idx;
                    hold_d  = HCW'(1);
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = TURN;
                end else if (hold_q == HCW'(MAX_HOLD)) begin
                    state_d  = TURN;
                    expire_d = 1'b1;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            TURN: begin
                elig = (others != 4'b0000) ? others : req;
                win  = pick4(elig, starved);
                if (win.vld) begin
                    state_d = GRANT;
                    owner_d = win.idx;
                    hold_d  = HCW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 2'd0;
                hold_d  = '0;
            end
        endcase
        gnt_d    = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
        gnt_id_d = (state_d == GRANT) ? owner_d : 2'd0;
        busy_d   = (state_d == GRANT);
    end

    // State, counters and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 2'd0;
            hold_q   <= '0;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_prio_grant_sched.sv
// Self-checking bench for prio_grant_sched: directed scenarios plus random
// request traffic, all compared against a cycle-level behavioural model.
module tb_prio_grant_sched;

    localparam int MH = 8;
    localparam int SL = 6;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       expire;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 = idle, 1 = owner holds grant, 2 = dead turn.
    int m_phase;
    int m_owner;
    int m_hold;
    int m_wait [4];
    bit m_exp;

    prio_grant_sched #(
        .MAX_HOLD     (MH),
        .STARVE_LIMIT (SL),
        .HCW          (4),
        .WCW          (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .expire (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [3:0] e, input logic [3:0] st);
        for (int i = 0; i < 4; i++) if (e[i] && st[i]) return i;
        for (int i = 0; i < 4; i++) if (e[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_hold  = 0;
        m_exp   = 1'b0;
        for (int i = 0; i < 4; i++) m_wait[i] = 0;
    endtask

    // Advance the model by one clock edge given the requests sampled there.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] st;
        logic [3:0] e;
        int         nw [4];
        for (int i = 0; i < 4; i++) begin
            st[i] = (m_wait[i] == SL);
            if (r[i] && !(m_phase == 1 && m_owner == i))
                nw[i] = (m_wait[i] + 1 > SL) ? SL : m_wait[i] + 1;
            else
                nw[i] = 0;
        end
        m_exp = 1'b0;
        if (m_phase == 0) begin
            if (r != 4'b0000) begin
                m_owner = model_pick(r, st);
                m_phase = 1;
                m_hold  = 1;
            end
        end else if (m_phase == 1) begin
            if (!r[m_owner]) begin
                m_phase = 2;
            end else if (m_hold == MH) begin
                m_phase = 2;
                m_exp   = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            e = r;
            e[m_owner] = 1'b0;
            if (e == 4'b0000) e = r;
            if (e != 4'b0000) begin
                m_owner = model_pick(e, st);
                m_phase = 1;
                m_hold  = 1;
            end else begin
                m_phase = 0;
            end
        end
        for (int i = 0; i < 4; i++) m_wait[i] = nw[i];
    endtask

    // Expected {gnt, gnt_id, busy, expire} from the model.
    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] id;
        g  = 4'b0000;
        id = 2'd0;
        if (m_phase == 1) begin
            g[m_owner] = 1'b1;
            id = 2'(m_owner);
        end
        return {g, id, (m_phase == 1), m_exp};
    endfunction

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step(4'b0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({gnt, gnt_id, busy, expire} !== 8'b0000_00_0_0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b", {gnt, gnt_id, busy, expire}, 8'b0000_00_0_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111);
        n_tests++;
        if ({gnt, gnt_id, busy, expire} !== 8'b0001_00_1_0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want %b", {gnt, gnt_id, busy, expire}, 8'b0001_00_1_0);
        end
        drain();
    endtask

    task automatic test_priority();
        logic [7:0] want [3];
        logic [3:0] stim [3];
        want[0] = 8'b0010_01_1_0; stim[0] = 4'b0110;
        want[1] = 8'b0000_00_0_0; stim[1] = 4'b0100;
        want[2] = 8'b0100_10_1_0; stim[2] = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step(stim[k]);
            n_tests++;
            if ({gnt, gnt_id, busy, expire} !== want[k]) begin
                n_fail++;
                $display("FAIL priority_handoff[%0d]: got %b want %b", k, {gnt, gnt_id, busy, expire}, want[k]);
            end
        end
        drain();
    endtask

    task automatic test_forced_release();
        int held;
        held = 0;
        for (int k = 0; k < MH; k++) begin
            step(4'b1001);
            if (gnt === 4'b0001) held++;
        end
        n_tests++;
        if (held != MH) begin
            n_fail++;
            $display("FAIL forced_hold_cycles: got %0d want %0d", held, MH);
        end
        step(4'b1001);
        n_tests++;
        if ({gnt, busy, expire} !== 6'b0000_0_1) begin
            n_fail++;
            $display("FAIL forced_expire: got %b want %b", {gnt, busy, expire}, 6'b0000_0_1);
        end
        step(4'b1001);
        n_tests++;
        if ({gnt, gnt_id, busy, expire} !== 8'b1000_11_1_0) begin
            n_fail++;
            $display("FAIL forced_next_owner: got %b want %b", {gnt, gnt_id, busy, expire}, 8'b1000_11_1_0);
        end
        drain();
    endtask

    task automatic test_expire_suppress();
        for (int k = 0; k < MH; k++) step(4'b0001);
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL suppress_last_hold: got %b want %b", gnt, 4'b0001);
        end
        step(4'b0000);
        n_tests++;
        if ({gnt, busy, expire} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL suppress_no_expire: got %b want %b", {gnt, busy, expire}, 6'b0000_0_0);
        end
        step(4'b0000);
        n_tests++;
        if ({gnt, busy, expire} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL suppress_idle: got %b want %b", {gnt, busy, expire}, 6'b0000_0_0);
        end
    endtask

    task automatic test_starvation();
        logic [3:0] r;
        bit         saw;
        bit         req0_set;
        saw      = 1'b0;
        req0_set = 1'b0;
        for (int k = 0; k < 40 && !saw; k++) begin
            r = 4'b1011;
            for (int j = 0; j < 2; j++)
                if (m_phase == 1 && m_owner == j && m_hold == 2) r[j] = 1'b0;
            step(r);
            n_tests++;
            if ({gnt, gnt_id, busy, expire} !== exp_vec()) begin
                n_fail++;
                $display("FAIL starve_step[%0d]: got %b want %b", k, {gnt, gnt_id, busy, expire}, exp_vec());
            end
            if (gnt === 4'b1000) begin
                saw      = 1'b1;
                req0_set = r[0];
            end
        end
        n_tests++;
        if ({saw, req0_set} !== 2'b11) begin
            n_fail++;
            $display("FAIL starve_grant: got saw=%0d req0=%0d want saw=1 req0=1", saw, req0_set);
        end
        drain();
    endtask

    task automatic test_async_reset();
        step(4'b0100);
        step(4'b0100);
        n_tests++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL async_pre_grant: got %b want %b", gnt, 4'b0100);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({gnt, gnt_id, busy, expire} !== 8'b0000_00_0_0) begin
            n_fail++;
            $display("FAIL async_clear: got %b want %b", {gnt, gnt_id, busy, expire}, 8'b0000_00_0_0);
        end
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(4'b0000);
            n_tests++;
            if ({gnt, busy} !== 5'b0000_0) begin
                n_fail++;
                $display("FAIL async_idle[%0d]: got %b want %b", k, {gnt, busy}, 5'b0000_0);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r);
            n_tests++;
            if ({gnt, gnt_id, busy, expire} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_step[%0d]: req=%b got %b want %b", k, r, {gnt, gnt_id, busy, expire}, exp_vec());
            end
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        test_reset();
        test_priority();
        test_forced_release();
        test_expire_suppress();
        test_starvation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/prio_grant_sched.md
Name: prio_grant_sched

Overview:
- Four-requester scheduler for one shared resource.
- Fixed priority (req[0] highest), plus a hold-time limit and starvation aging.
- Sits in front of a shared FSM-driven datapath. Issues a registered one-hot grant.
- Built as a 3-state controller; outputs are flops decoded from nextstate.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles per ownership (>=1).
- STARVE_LIMIT, 16: wait cycles after which a requester is "starved" (>=1).
- HCW, 4: hold counter width; must hold MAX_HOLD.
- WCW, 5: wait counter width; must hold STARVE_LIMIT.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, 4: level requests; bit i = requester i.
- gnt, output, 4: registered one-hot grant, or 0.
- gnt_id, output, 2: index of the set gnt bit; 0 when gnt==0.
- busy, output, 1: registered; 1 while any gnt bit is set.
- expire, output, 1: registered 1-cycle pulse on forced release.

Behaviour:
- Reset: clk = clock; reset rst_n, asynchronous, active-low.
  - While rst_n low: state=IDLE; gnt=0, gnt_id=0, busy=0, expire=0; all counters 0.
  - Reset asserted mid-GRANT clears outputs immediately, without waiting for clk.
- States: IDLE, GRANT, TURN. Illegal encodings go to IDLE.
- IDLE: any req set -> GRANT with the arbitration winner as owner. Else stay.
- GRANT: owner's req low -> TURN (normal release). Else hold_cnt==MAX_HOLD -> TURN and expire=1 (forced release). Else stay.
- TURN: exactly one dead cycle with gnt=0. Arbitrates like IDLE: any eligible req -> GRANT, else IDLE.
- Arbitration (IDLE/TURN):
  - In TURN the previous owner is masked out if any other req is set.
  - Among eligible requesters with wait_cnt==STARVE_LIMIT, lowest index wins.
  - Otherwise lowest set req index wins.
- Latency:
  - gnt rises at the first clk edge after req is sampled in IDLE/TURN.
  - gnt falls at the edge after the owner's req low is sampled.
  - Back-to-back ownership always has exactly one gnt=0 cycle between owners.
- hold_cnt:
  - Loads 1 on entry to GRANT; increments each GRANT cycle.
  - The owner therefore holds gnt for exactly MAX_HOLD cycles if req stays high.
- expire: asserted in the same cycle gnt first reads 0 after a forced release.
  - Owner dropping req in the same cycle hold_cnt==MAX_HOLD counts as normal release: no expire.
- wait_cnt[i]:
  - Increments while req[i]=1 and gnt[i]=0; saturates at STARVE_LIMIT.
  - Clears when gnt[i] is set or req[i]=0.
- Owner's req is ignored once the grant is decided. Requests changing during TURN are sampled live.
- Output flops take values decoded from nextstate/next owner (dff-onState), never from current state.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, GRANT=2'd1, TURN=2'd2;
  - NREQ=4;
  - function pick4(req, starved) returning winner index and valid.
- Sub-module prio_sched_wait_cnt: per-requester saturating wait counter (inputs req_i, gnt_i; output starved). Instantiated 4x.
- No state-name debug logic is required in this block.

Test Plan:
- Reset and startup: hold rst_n=0 with req=4'b1111, then release -> gnt=0, busy=0 during reset; gnt=4'b0001, gnt_id=0, busy=1 one edge after release.
- Fixed priority and handoff: req=4'b0110 from IDLE -> gnt=4'b0010, gnt_id=1; drop req[1] -> gnt=0 for one cycle (TURN), then gnt=4'b0100, gnt_id=2.
- Forced release: MAX_HOLD=8, req[0] and req[3] held -> gnt[0] high exactly 8 cycles; expire=1 for 1 cycle with gnt=0; next cycle gnt=4'b1000 (owner masked).
- Expire suppression: req[0] drops in the cycle hold_cnt==MAX_HOLD -> expire stays 0, then TURN -> IDLE.
- Starvation: STARVE_LIMIT=6, req[3] held; req[0]/req[1] each hold 2 cycles and re-request immediately -> once wait_cnt[3]==6, next arbitration grants gnt=4'b1000 despite req[0] set.
- Async reset mid-GRANT: drive rst_n low between edges while gnt=4'b0100 -> gnt, busy, expire go 0 without a clock edge; after release with req=0 state stays IDLE.
